ecc_modarith_ctrl: RTL and testbench

//  CV-X-IF coprocessor controller for the ECC accelerator with a built-in modular datapath.

---
 rtl/ecc_modarith_ctrl.sv | 138 +++++++++++++
 tb/tb_ecc_modarith_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ecc_modarith_ctrl.sv
// ecc_modarith_ctrl: CV-X-IF controller running modular add/sub on a modulus register,
// with an in-order result FIFO between the datapath and the core result channel.
module ecc_modarith_ctrl #(
    parameter int XLEN      = 64,
    parameter int ID_WIDTH  = 3,
    parameter int RES_DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [XLEN-1:0]     issue_rs1_i,
    input  logic [XLEN-1:0]     issue_rs2_i,
    input  logic [1:0]          issue_rs_valid_i,
    output logic                issue_accept_o,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [XLEN-1:0]     result_data_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o,
    output logic                busy_o
);
    typedef enum logic [1:0] {IDLE, CALC, REDUCE} state_t;
    localparam logic [1:0] OP_SET = 2'd0, OP_ADD = 2'd1, OP_SUB = 2'd2, OP_GET = 2'd3;
    localparam int PW = RES_DEPTH > 1 ? $clog2(RES_DEPTH) : 1;
    localparam int CW = $clog2(RES_DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(RES_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(RES_DEPTH);

    state_t              state_q;
    logic [1:0]          op_q;
    logic [ID_WIDTH-1:0] id_q;
    logic [4:0]          rd_q;
    logic [XLEN-1:0]     a_q, b_q, mod_q;
    logic [XLEN:0]       raw_q;

    logic [ID_WIDTH-1:0] mem_id   [RES_DEPTH];
    logic [XLEN-1:0]     mem_data [RES_DEPTH];
    logic [4:0]          mem_rd   [RES_DEPTH];
    logic                mem_we   [RES_DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q;

    logic [2:0]      funct3;
    logic            rs_ok, xfer, push, pop, red_we, unused_instr;
    logic [XLEN:0]   mod_ext, add_diff;
    logic [XLEN-1:0] add_red, sub_red, red_data;

    assign funct3         = issue_instr_i[14:12];
    assign unused_instr   = ^{issue_instr_i[31:15], issue_instr_i[6:0]};
    assign rs_ok          = (funct3 == 3'd0) ? issue_rs_valid_i[0] :
                            (funct3 == 3'd1 || funct3 == 3'd2) ? &issue_rs_valid_i : 1'b1;
    assign issue_accept_o = ~funct3[2];
    assign issue_ready_o  = (state_q == IDLE) && (count_q < DEPTH_C) && rs_ok;
    assign xfer           = issue_valid_i && issue_ready_o;

    assign push           = state_q == REDUCE;
    assign result_valid_o = count_q != '0;
    assign pop            = result_valid_o && result_ready_i;
    assign busy_o         = (state_q != IDLE) || result_valid_o;

    assign result_id_o    = result_valid_o ? mem_id[rd_ptr_q]   : '0;
    assign result_data_o  = result_valid_o ? mem_data[rd_ptr_q] : '0;
    assign result_rd_o    = result_valid_o ? mem_rd[rd_ptr_q]   : '0;
    assign result_we_o    = result_valid_o && mem_we[rd_ptr_q];

    // Final reduction: one conditional subtract/add of the modulus brings the raw sum/difference back into range.
    always_comb begin
        mod_ext  = {1'b0, mod_q};
        add_diff = raw_q - mod_ext;
        add_red  = (mod_q != '0 && raw_q >= mod_ext) ? add_diff[XLEN-1:0] : raw_q[XLEN-1:0];
        sub_red  = (mod_q != '0 && raw_q[XLEN]) ? raw_q[XLEN-1:0] + mod_q : raw_q[XLEN-1:0];
        red_data = (op_q == OP_ADD) ? add_red :
                   (op_q == OP_SUB) ? sub_red :
                   (op_q == OP_GET) ? mod_q : '0;
        red_we   = op_q != OP_SET;
    end

    // Operation FSM: latch a supported request, form the raw result, then reduce and push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= OP_SET;
            id_q    <= '0;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mod_q   <= '0;
            raw_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (xfer && issue_accept_o) begin
                    state_q <= CALC;
                    op_q    <= funct3[1:0];
                    id_q    <= issue_id_i;
                    rd_q    <= issue_instr_i[11:7];
                    a_q     <= issue_rs1_i;
                    b_q     <= issue_rs2_i;
                end
                CALC: begin
                    state_q <= REDUCE;
                    raw_q   <= (op_q == OP_SUB) ? {1'b0, a_q} - {1'b0, b_q} : {1'b0, a_q} + {1'b0, b_q};
                    if (op_q == OP_SET) mod_q <= a_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Result FIFO: circular buffer, push from REDUCE, pop on the core handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < RES_DEPTH; i++) begin
                mem_id[i]   <= '0;
                mem_data[i] <= '0;
                mem_rd[i]   <= '0;
                mem_we[i]   <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_id[wr_ptr_q]   <= id_q;
                mem_data[wr_ptr_q] <= red_data;
                mem_rd[wr_ptr_q]   <= rd_q;
                mem_we[wr_ptr_q]   <= red_we;
                wr_ptr_q           <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            if (push && !pop) count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end
endmodule

// File: tb/tb_ecc_modarith_ctrl.sv
// tb_ecc_modarith_ctrl: directed vectors with hand-computed results for the modular arithmetic controller.
module tb_ecc_modarith_ctrl;
    localparam logic [2:0] F_SET = 3'd0, F_ADD = 3'd1, F_SUB = 3'd2, F_GET = 3'd3, F_BAD = 3'd7;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        issue_valid_i = 1'b0;
    logic        issue_ready_o;
    logic [31:0] issue_instr_i = '0;
    logic [2:0]  issue_id_i = '0;
    logic [63:0] issue_rs1_i = '0;
    logic [63:0] issue_rs2_i = '0;
    logic [1:0]  issue_rs_valid_i = '0;
    logic        issue_accept_o;
    logic        result_valid_o;
    logic        result_ready_i = 1'b0;
    logic [2:0]  result_id_o;
    logic [63:0] result_data_o;
    logic [4:0]  result_rd_o;
    logic        result_we_o;
    logic        busy_o;
    int          tests = 0;
    int          fails = 0;

    ecc_modarith_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
        .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
        .issue_rs_valid_i(issue_rs_valid_i), .issue_accept_o(issue_accept_o),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_id_o(result_id_o), .result_data_o(result_data_o),
        .result_rd_o(result_rd_o), .result_we_o(result_we_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic [2:0] f3, input logic [2:0] id, input logic [4:0] rd,
                           input logic [63:0] a, input logic [63:0] b, input logic [1:0] rsv);
        issue_instr_i    = {17'b0, f3, rd, 7'h0b};
        issue_id_i       = id;
        issue_rs1_i      = a;
        issue_rs2_i      = b;
        issue_rs_valid_i = rsv;
        #1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [2:0] id, input logic [4:0] rd,
                         input logic [63:0] a, input logic [63:0] b);
        int n = 0;
        set_req(f3, id, rd, a, b, 2'b11);
        issue_valid_i = 1'b1;
        while (!issue_ready_o && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (n == 50) check("issue_timeout", 64'd0, 64'd1);
        @(posedge clk_i); #1;
        issue_valid_i = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [2:0] id, input logic [63:0] d,
                              input logic [4:0] rd, input logic we);
        int n = 0;
        while (!result_valid_o && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        check({tag, "_valid"}, 64'(result_valid_o), 64'd1);
        check({tag, "_id"}, 64'(result_id_o), 64'(id));
        check({tag, "_data"}, result_data_o, d);
        check({tag, "_rd"}, 64'(result_rd_o), 64'(rd));
        check({tag, "_we"}, 64'(result_we_o), 64'(we));
        result_ready_i = 1'b1;
        @(posedge clk_i); #1;
        result_ready_i = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_valid", 64'(result_valid_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_data", result_data_o, 64'd0);
        check("rst_ready_no_rs", 64'(issue_ready_o), 64'd0);
        rst_ni = 1'b1;
        issue_rs_valid_i = 2'b11;
        #1;
        check("rst_ready", 64'(issue_ready_o), 64'd1);

        issue(F_SET, 3'd6, 5'd3, 64'd97, 64'd0);
        get_result("setmod", 3'd6, 64'd0, 5'd3, 1'b0);

        issue(F_ADD, 3'd1, 5'd5, 64'd50, 64'd60);
        @(posedge clk_i); #1;
        check("lat_t2_valid", 64'(result_valid_o), 64'd0);
        @(posedge clk_i); #1;
        check("lat_t3_valid", 64'(result_valid_o), 64'd1);
        check("b2b_ready", 64'(issue_ready_o), 64'd1);
        get_result("add", 3'd1, 64'd13, 5'd5, 1'b1);

        issue(F_SUB, 3'd2, 5'd6, 64'd10, 64'd20);
        get_result("sub_wrap", 3'd2, 64'd87, 5'd6, 1'b1);
        issue(F_SUB, 3'd3, 5'd7, 64'd20, 64'd10);
        get_result("sub", 3'd3, 64'd10, 5'd7, 1'b1);
        issue(F_GET, 3'd4, 5'd8, 64'd0, 64'd0);
        get_result("getmod", 3'd4, 64'd97, 5'd8, 1'b1);

        issue(F_SET, 3'd5, 5'd0, 64'd0, 64'd0);
        get_result("setmod0", 3'd5, 64'd0, 5'd0, 1'b0);
        issue(F_ADD, 3'd0, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        get_result("add_mod0", 3'd0, 64'd1, 5'd9, 1'b1);

        issue(F_ADD, 3'd2, 5'd10, 64'd1, 64'd2);
        issue(F_ADD, 3'd3, 5'd11, 64'd3, 64'd4);
        repeat (3) @(posedge clk_i);
        set_req(F_ADD, 3'd4, 5'd12, 64'd5, 64'd6, 2'b11);
        issue_valid_i = 1'b1;
        #1;
        check("full_ready", 64'(issue_ready_o), 64'd0);
        check("full_busy", 64'(busy_o), 64'd1);
        check("full_head_id", 64'(result_id_o), 64'd2);
        issue_valid_i = 1'b0;
        get_result("drain0", 3'd2, 64'd3, 5'd10, 1'b1);
        check("drain_ready", 64'(issue_ready_o), 64'd1);
        issue(F_ADD, 3'd4, 5'd12, 64'd5, 64'd6);
        get_result("drain1", 3'd3, 64'd7, 5'd11, 1'b1);
        get_result("drain2", 3'd4, 64'd11, 5'd12, 1'b1);

        set_req(F_BAD, 3'd1, 5'd1, 64'd1, 64'd1, 2'b00);
        issue_valid_i = 1'b1;
        #1;
        check("bad_accept", 64'(issue_accept_o), 64'd0);
        check("bad_ready", 64'(issue_ready_o), 64'd1);
        @(posedge clk_i); #1;
        issue_valid_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        check("bad_valid", 64'(result_valid_o), 64'd0);
        check("bad_busy", 64'(busy_o), 64'd0);
        set_req(F_ADD, 3'd1, 5'd1, 64'd1, 64'd1, 2'b01);
        check("add_rs01_ready", 64'(issue_ready_o), 64'd0);

        issue(F_SET, 3'd0, 5'd0, 64'd97, 64'd0);
        get_result("setmod97", 3'd0, 64'd0, 5'd0, 1'b0);
        issue(F_ADD, 3'd5, 5'd5, 64'd50, 64'd60);
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        #1;
        check("midrst_valid", 64'(result_valid_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        check("midrst_noresult", 64'(result_valid_o), 64'd0);
        issue(F_GET, 3'd7, 5'd9, 64'd0, 64'd0);
        get_result("getmod_rst", 3'd7, 64'd0, 5'd9, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
